// File: rtl/dmem_arb_pkg.sv
// Shared types and sizes for the two-port data-memory arbiter.
package dmem_arb_pkg;

  localparam int unsigned NUM_PORTS = 2;
  localparam int unsigned MEM_BYTES = 4096;
  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned DATA_W    = 32;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    ACK
  } arb_state_e;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: on a tie the port not served last wins.
module rr_pick2
  import dmem_arb_pkg::*;
(
  input  logic [NUM_PORTS-1:0] req,
  input  logic                 last,
  output logic                 grant_valid,
  output logic                 grant_idx
);

  always_comb begin
    grant_valid = |req;
    grant_idx   = (&req) ? ~last : req[1];
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter, fixed 3-cycle IDLE/ACCESS/ACK sequence per access.
// Define DMEM_ARB_ALIGN_CHECK_EN to reject word-misaligned addresses with an error ack.
module dmem_arbiter
  import dmem_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] adr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  output logic              err0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] adr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
  output logic              err1,
  output logic [ADDR_W-1:0] mem_adr,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_data_out
);

  arb_state_e        state_q;
  logic              last_q;
  logic              win_q;
  logic              lat_we_q;
  logic [ADDR_W-1:0] lat_adr_q;
  logic [DATA_W-1:0] lat_wdata_q;

  logic              grant_valid;
  logic              grant_idx;
  logic              misalign;
  logic              access_ok;

  rr_pick2 u_pick (
    .req         ({req1, req0}),
    .last        (last_q),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

`ifdef DMEM_ARB_ALIGN_CHECK_EN
  assign misalign = (lat_adr_q[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  // rst gates the strobes so a reset landing on the ACCESS edge never commits a write.
  assign access_ok   = (state_q == ACCESS) && !misalign && !rst;
  assign mem_write   = access_ok && lat_we_q;
  assign mem_read    = access_ok && !lat_we_q;
  assign mem_adr     = (state_q == ACCESS) ? lat_adr_q : '0;
  assign mem_data_in = (state_q == ACCESS) ? lat_wdata_q : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      win_q       <= 1'b0;
      lat_we_q    <= 1'b0;
      lat_adr_q   <= '0;
      lat_wdata_q <= '0;
      ack0        <= 1'b0;
      ack1        <= 1'b0;
      err0        <= 1'b0;
      err1        <= 1'b0;
      rdata0      <= '0;
      rdata1      <= '0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      err0 <= 1'b0;
      err1 <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_valid) begin
            lat_we_q    <= grant_idx ? we1 : we0;
            lat_adr_q   <= grant_idx ? adr1 : adr0;
            lat_wdata_q <= grant_idx ? wdata1 : wdata0;
            win_q       <= grant_idx;
            last_q      <= grant_idx;
            state_q     <= ACCESS;
          end
        end
        ACCESS: begin
          if (!lat_we_q && !misalign) begin
            if (win_q) rdata1 <= mem_data_out;
            else       rdata0 <= mem_data_out;
          end
          if (win_q) begin
            ack1 <= 1'b1;
            err1 <= misalign;
          end else begin
            ack0 <= 1'b1;
            err0 <= misalign;
          end
          state_q <= ACK;
        end
        ACK:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: vector table plus tie, fairness, reset-abort and
// alignment sequences, with acks checked against a queue of expected completions.
module tb_dmem_arbiter;

  logic        clk;
  logic        rst;
  logic        req0, we0, ack0, err0;
  logic        req1, we1, ack1, err1;
  logic [31:0] adr0, wdata0, rdata0;
  logic [31:0] adr1, wdata1, rdata1;
  logic [31:0] mem_adr, mem_data_in, mem_data_out;
  logic        mem_read, mem_write;

  dmem_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .req0         (req0),
    .we0          (we0),
    .adr0         (adr0),
    .wdata0       (wdata0),
    .ack0         (ack0),
    .rdata0       (rdata0),
    .err0         (err0),
    .req1         (req1),
    .we1          (we1),
    .adr1         (adr1),
    .wdata1       (wdata1),
    .ack1         (ack1),
    .rdata1       (rdata1),
    .err1         (err1),
    .mem_adr      (mem_adr),
    .mem_data_in  (mem_data_in),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_data_out (mem_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Big-endian byte memory, 4 KiB, combinational read, write on posedge.
  logic [7:0]  mem [0:4095];
  logic        tb_init;
  logic [11:0] a0, a1, a2, a3;
  assign a0 = mem_adr[11:0];
  assign a1 = a0 + 12'd1;
  assign a2 = a0 + 12'd2;
  assign a3 = a0 + 12'd3;
  assign mem_data_out = {mem[a0], mem[a1], mem[a2], mem[a3]};

  always @(posedge clk) begin
    if (tb_init) begin
      for (int i = 0; i < 4096; i++) mem[i] <= 8'h00;
    end else if (mem_write) begin
      mem[a0] <= mem_data_in[31:24];
      mem[a1] <= mem_data_in[23:16];
      mem[a2] <= mem_data_in[15:8];
      mem[a3] <= mem_data_in[7:0];
    end
  end

`ifdef DMEM_ARB_ALIGN_CHECK_EN
  localparam logic        MisErr   = 1'b1;
  localparam int          MisIo    = 0;
  localparam logic [31:0] MisBytes = 32'h0000_0000;
  localparam logic [31:0] RdAfter  = 32'h0000_0000;
`else
  localparam logic        MisErr   = 1'b0;
  localparam int          MisIo    = 1;
  localparam logic [31:0] MisBytes = 32'h5566_7788;
  localparam logic [31:0] RdAfter  = 32'h0000_5566;
`endif

  typedef struct {
    logic        port;
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  typedef struct {
    logic        port;
    logic        we;
    logic [31:0] adr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[10];
  int   checks;
  int   failures;
  int   cyc;
  int   rem0, rem1;
  int   io_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic monitor();
    exp_t e;
    chk("rw_exclusive", 32'(mem_read & mem_write), 32'd0);
    if (mem_read || mem_write) io_cnt++;
    if (ack0 || ack1) begin
      chk("ack_onehot", 32'(ack0 & ack1), 32'd0);
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_ack actual ack0=%0b ack1=%0b required none", ack0, ack1);
      end else begin
        e = sb.pop_front();
        chk("ack_port", 32'(ack1), 32'(e.port));
        chk("rdata", ack1 ? rdata1 : rdata0, e.rdata);
        chk("err", 32'(ack1 ? err1 : err0), 32'(e.err));
        chk("ack_cycle", 32'(cyc), 32'(e.cyc));
      end
      if (ack0 && rem0 > 0) rem0--;
      if (ack1 && rem1 > 0) rem1--;
    end
  endtask

  task automatic cycle_end();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input logic p, input logic we, input logic [31:0] adr,
                          input logic [31:0] wd);
    if (p) begin
      we1 = we; adr1 = adr; wdata1 = wd;
    end else begin
      we0 = we; adr0 = adr; wdata0 = wd;
    end
  endtask

  task automatic push(input logic p, input logic [31:0] rd, input logic err, input int c);
    exp_t e;
    e.port = p; e.rdata = rd; e.err = err; e.cyc = c;
    sb.push_back(e);
  endtask

  // Each port keeps req high while it still has accesses outstanding.
  task automatic run_batch(input int exp_io, input string tag);
    cyc    = 0;
    io_cnt = 0;
    while ((rem0 > 0 || rem1 > 0) && cyc < 40) begin
      req0 = (rem0 > 0);
      req1 = (rem1 > 0);
      cycle_end();
      cyc++;
    end
    req0 = 1'b0;
    req1 = 1'b0;
    chk({tag, "_done"}, 32'(rem0 + rem1), 32'd0);
    chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
    chk({tag, "_mem_io"}, 32'(io_cnt), 32'(exp_io));
    sb.delete();
    rem0 = 0;
    rem1 = 0;
  endtask

  task automatic idle_check(input string tag);
    @(negedge clk);
    monitor();
    chk({tag, "_idle_adr"}, mem_adr, 32'd0);
    chk({tag, "_idle_wdata"}, mem_data_in, 32'd0);
    chk({tag, "_idle_rw"}, 32'({mem_read, mem_write}), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ack"}, 32'({ack0, ack1}), 32'd0);
    chk({tag, "_err"}, 32'({err0, err1}), 32'd0);
    chk({tag, "_rdata0"}, rdata0, 32'd0);
    chk({tag, "_rdata1"}, rdata1, 32'd0);
    chk({tag, "_rw"}, 32'({mem_read, mem_write}), 32'd0);
    chk({tag, "_adr"}, mem_adr, 32'd0);
    chk({tag, "_wdata"}, mem_data_in, 32'd0);
  endtask

  task automatic reset_dut();
    rst  = 1'b1;
    req0 = 1'b0;
    req1 = 1'b0;
    cycle_end();
    cycle_end();
    rst = 1'b0;
  endtask

  task automatic chk_bytes(input string tag, input int base, input logic [31:0] exp);
    chk(tag, {mem[base], mem[base + 1], mem[base + 2], mem[base + 3]}, exp);
  endtask

  initial begin
    checks = 0; failures = 0; cyc = 0; rem0 = 0; rem1 = 0; io_cnt = 0;
    rst = 1'b1; tb_init = 1'b1;
    req0 = 0; we0 = 0; adr0 = '0; wdata0 = '0;
    req1 = 0; we1 = 0; adr1 = '0; wdata1 = '0;

    vecs[0] = '{1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000};
    vecs[1] = '{1'b0, 1'b0, 32'h0000_0010, 32'h0000_0000, 32'hDEAD_BEEF};
    vecs[2] = '{1'b1, 1'b1, 32'h0000_0100, 32'hCAFE_F00D, 32'h0000_0000};
    vecs[3] = '{1'b1, 1'b0, 32'h0000_0100, 32'h0000_0000, 32'hCAFE_F00D};
    vecs[4] = '{1'b0, 1'b1, 32'h0000_0FFC, 32'h1122_3344, 32'hDEAD_BEEF};
    vecs[5] = '{1'b1, 1'b0, 32'h0000_0FFC, 32'h0000_0000, 32'h1122_3344};
    vecs[6] = '{1'b0, 1'b0, 32'h0000_1010, 32'h0000_0000, 32'hDEAD_BEEF};
    vecs[7] = '{1'b1, 1'b1, 32'h0000_0104, 32'hA5A5_5A5A, 32'h1122_3344};
    vecs[8] = '{1'b0, 1'b0, 32'h0000_0104, 32'h0000_0000, 32'hA5A5_5A5A};
    vecs[9] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0000_0000, 32'hDEAD_BEEF};

    @(posedge clk);
    #1;
    tb_init = 1'b0;
    @(negedge clk);
    check_zero("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      set_port(vecs[i].port, vecs[i].we, vecs[i].adr, vecs[i].wdata);
      if (vecs[i].port) rem1 = 1;
      else rem0 = 1;
      push(vecs[i].port, vecs[i].exp_rdata, 1'b0, 2);
      run_batch(1, $sformatf("vec%0d", i));
      idle_check($sformatf("vec%0d", i));
    end
    chk_bytes("mem_0x10", 32'h10, 32'hDEAD_BEEF);
    chk_bytes("mem_0xffc", 32'hFFC, 32'h1122_3344);
    chk_bytes("mem_0x104", 32'h104, 32'hA5A5_5A5A);

    // Tie right after reset goes to port 0; after a port-0 grant a tie goes to port 1.
    reset_dut();
    set_port(1'b0, 1'b0, 32'h10, 32'h0);
    set_port(1'b1, 1'b0, 32'h100, 32'h0);
    rem0 = 1; rem1 = 1;
    push(1'b0, 32'hDEAD_BEEF, 1'b0, 2);
    push(1'b1, 32'hCAFE_F00D, 1'b0, 5);
    run_batch(2, "tie1");
    set_port(1'b0, 1'b0, 32'h104, 32'h0);
    rem0 = 1;
    push(1'b0, 32'hA5A5_5A5A, 1'b0, 2);
    run_batch(1, "p0_only");
    set_port(1'b1, 1'b0, 32'hFFC, 32'h0);
    set_port(1'b0, 1'b0, 32'h10, 32'h0);
    rem0 = 1; rem1 = 1;
    push(1'b1, 32'h1122_3344, 1'b0, 2);
    push(1'b0, 32'hDEAD_BEEF, 1'b0, 5);
    run_batch(2, "tie2");

    // Both ports requesting continuously must alternate.
    reset_dut();
    set_port(1'b0, 1'b0, 32'h10, 32'h0);
    set_port(1'b1, 1'b0, 32'h100, 32'h0);
    rem0 = 2; rem1 = 2;
    push(1'b0, 32'hDEAD_BEEF, 1'b0, 2);
    push(1'b1, 32'hCAFE_F00D, 1'b0, 5);
    push(1'b0, 32'hDEAD_BEEF, 1'b0, 8);
    push(1'b1, 32'hCAFE_F00D, 1'b0, 11);
    run_batch(4, "alt");

    // Reset landing on the ACCESS cycle of a write aborts it.
    io_cnt = 0;
    set_port(1'b0, 1'b1, 32'h20, 32'h1234_5678);
    req0 = 1'b1;
    cycle_end();
    rst  = 1'b1;
    req0 = 1'b0;
    @(negedge clk);
    chk("rst_access_mem_write", 32'(mem_write), 32'd0);
    monitor();
    @(posedge clk);
    #1;
    @(negedge clk);
    check_zero("rst_abort");
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) cycle_end();
    chk("rst_abort_io", 32'(io_cnt), 32'd0);
    chk_bytes("rst_abort_mem_0x20", 32'h20, 32'h0);

    // Misaligned write from port 1, then an aligned read over the same word.
    set_port(1'b1, 1'b1, 32'h22, 32'h5566_7788);
    rem1 = 1;
    push(1'b1, 32'h0, MisErr, 2);
    run_batch(MisIo, "misalign");
    chk_bytes("misalign_mem_0x22", 32'h22, MisBytes);
    set_port(1'b1, 1'b0, 32'h20, 32'h0);
    rem1 = 1;
    push(1'b1, RdAfter, 1'b0, 2);
    run_batch(1, "rd_after_misalign");
    idle_check("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
